// File: rtl/pifo_sorted_reg.sv
// Push-in first-out queue held as a sorted register array.
// Slot 0 is always the head, so the output side is a plain register read.
// A push lands at the first slot whose rank is strictly worse than the new
// rank, which keeps equal ranks in arrival order.
module pifo_sorted_reg #(
  parameter int DEPTH      = 8,
  parameter int RANK_WIDTH = 16,
  parameter int META_WIDTH = 32,
  parameter int ORDER      = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [RANK_WIDTH-1:0]        in_rank,
  input  logic [META_WIDTH-1:0]        in_meta,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [RANK_WIDTH-1:0]        out_rank,
  output logic [META_WIDTH-1:0]        out_meta,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow
);

  localparam int CW = $clog2(DEPTH+1);
  // Invalid slots carry the rank that loses every comparison.
  localparam logic [RANK_WIDTH-1:0] WORST_RANK =
    (ORDER == 0) ? {RANK_WIDTH{1'b1}} : {RANK_WIDTH{1'b0}};

  // True when a stored rank must sit behind a newly arriving rank.
  function automatic logic is_worse(input logic [RANK_WIDTH-1:0] slot_rank,
                                    input logic [RANK_WIDTH-1:0] new_rank);
    if (ORDER == 0) begin
      is_worse = (slot_rank > new_rank);
    end else begin
      is_worse = (slot_rank < new_rank);
    end
  endfunction

  // Stored state
  logic [RANK_WIDTH-1:0] rank_r [DEPTH];
  logic [META_WIDTH-1:0] meta_r [DEPTH];
  logic [DEPTH-1:0]      valid_r;
  logic [CW-1:0]         count_r;
  logic                  full_r;
  logic                  empty_r;
  logic                  overflow_r;

  // Handshake
  logic                  in_ready_s;
  logic                  push_s;
  logic                  pop_s;

  // Array after an optional pop (head removed, everything shifted up)
  logic [RANK_WIDTH-1:0] base_rank_s [DEPTH];
  logic [META_WIDTH-1:0] base_meta_s [DEPTH];
  logic [DEPTH-1:0]      base_valid_s;
  logic [CW-1:0]         base_count_s;

  // Same array shifted down one slot, used behind the insertion point
  logic [RANK_WIDTH-1:0] dn_rank_s [DEPTH];
  logic [META_WIDTH-1:0] dn_meta_s [DEPTH];
  logic [DEPTH-1:0]      dn_valid_s;

  logic [CW-1:0]         ins_pos_s;

  // Next state
  logic [RANK_WIDTH-1:0] nxt_rank_s [DEPTH];
  logic [META_WIDTH-1:0] nxt_meta_s [DEPTH];
  logic [DEPTH-1:0]      nxt_valid_s;
  logic [CW-1:0]         nxt_count_s;
  logic                  nxt_overflow_s;

  // A full queue still accepts a push when the head leaves in the same cycle.
  always_comb begin
    in_ready_s = !full_r || out_ready;
    pop_s      = valid_r[0] && out_ready;
    push_s     = in_valid && in_ready_s;
  end

  // Remove the head when popping; the freed tail slot becomes invalid.
  always_comb begin
    base_rank_s  = rank_r;
    base_meta_s  = meta_r;
    base_valid_s = valid_r;
    base_count_s = count_r;
    if (pop_s) begin
      for (int i = 0; i < DEPTH-1; i++) begin
        base_rank_s[i]  = rank_r[i+1];
        base_meta_s[i]  = meta_r[i+1];
        base_valid_s[i] = valid_r[i+1];
      end
      base_rank_s[DEPTH-1]  = WORST_RANK;
      base_meta_s[DEPTH-1]  = {META_WIDTH{1'b0}};
      base_valid_s[DEPTH-1] = 1'b0;
      base_count_s          = count_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      base_count_s = count_r;
    end
  end

  // Down-shifted copy of the post-pop array; slot 0 is never used from it.
  always_comb begin
    dn_rank_s     = base_rank_s;
    dn_meta_s     = base_meta_s;
    dn_valid_s    = base_valid_s;
    for (int i = 1; i < DEPTH; i++) begin
      dn_rank_s[i]  = base_rank_s[i-1];
      dn_meta_s[i]  = base_meta_s[i-1];
      dn_valid_s[i] = base_valid_s[i-1];
    end
  end

  // Insertion point: first valid slot strictly worse than the new rank,
  // otherwise just behind the last valid entry.
  always_comb begin
    ins_pos_s = base_count_s;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (base_valid_s[i] && is_worse(base_rank_s[i], in_rank)) begin
        ins_pos_s = CW'(i);
      end else begin
        ins_pos_s = ins_pos_s;
      end
    end
  end

  // Build next array: flush wins, otherwise pop result plus optional insert.
  always_comb begin
    nxt_rank_s     = base_rank_s;
    nxt_meta_s     = base_meta_s;
    nxt_valid_s    = base_valid_s;
    nxt_count_s    = base_count_s;
    nxt_overflow_s = 1'b0;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        nxt_rank_s[i] = WORST_RANK;
        nxt_meta_s[i] = {META_WIDTH{1'b0}};
      end
      nxt_valid_s = {DEPTH{1'b0}};
      nxt_count_s = {CW{1'b0}};
    end else begin
      nxt_overflow_s = in_valid && !in_ready_s;
      if (push_s) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == ins_pos_s) begin
            nxt_rank_s[i]  = in_rank;
            nxt_meta_s[i]  = in_meta;
            nxt_valid_s[i] = 1'b1;
          end else if (CW'(i) > ins_pos_s) begin
            nxt_rank_s[i]  = dn_rank_s[i];
            nxt_meta_s[i]  = dn_meta_s[i];
            nxt_valid_s[i] = dn_valid_s[i];
          end else begin
            nxt_rank_s[i]  = base_rank_s[i];
            nxt_meta_s[i]  = base_meta_s[i];
            nxt_valid_s[i] = base_valid_s[i];
          end
        end
        nxt_count_s = base_count_s + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        nxt_count_s = base_count_s;
      end
    end
  end

  // State registers; reset clears the queue and zeroes the head outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rank_r[i] <= WORST_RANK;
        meta_r[i] <= {META_WIDTH{1'b0}};
      end
      rank_r[0]  <= {RANK_WIDTH{1'b0}};
      valid_r    <= {DEPTH{1'b0}};
      count_r    <= {CW{1'b0}};
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      rank_r     <= nxt_rank_s;
      meta_r     <= nxt_meta_s;
      valid_r    <= nxt_valid_s;
      count_r    <= nxt_count_s;
      full_r     <= (nxt_count_s == CW'(DEPTH));
      empty_r    <= (nxt_count_s == {CW{1'b0}});
      overflow_r <= nxt_overflow_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = valid_r[0];
  assign out_rank  = rank_r[0];
  assign out_meta  = meta_r[0];
  assign count     = count_r;
  assign full      = full_r;
  assign empty     = empty_r;
  assign overflow  = overflow_r;

endmodule
